// File: rtl/dma_rd_desc_arbiter.sv
// Round-robin merge of weights (W) and pixels (X) read descriptors onto one DMA port, with per-source credits.
// Latency: one cycle from accepted source descriptor to m_d_valid; status completions free credits one cycle later.
// Backpressure: a registered output slot stalls on !m_d_ready; a source at its credit limit is skipped, never blocks the other.
module dma_rd_desc_arbiter #(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_LEN_WIDTH   = 32,
   parameter int AXI_TAG_WIDTH   = 8,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                      clk,
   input  logic                      rstn,
   // weights descriptor stream
   input  logic [AXI_ADDR_WIDTH-1:0] s_wd_addr,
   input  logic [AXI_LEN_WIDTH-1:0]  s_wd_len,
   input  logic                      s_wd_valid,
   output logic                      s_wd_ready,
   // pixels descriptor stream
   input  logic [AXI_ADDR_WIDTH-1:0] s_xd_addr,
   input  logic [AXI_LEN_WIDTH-1:0]  s_xd_len,
   input  logic                      s_xd_valid,
   output logic                      s_xd_ready,
   // merged descriptor towards the DMA
   output logic [AXI_ADDR_WIDTH-1:0] m_d_addr,
   output logic [AXI_LEN_WIDTH-1:0]  m_d_len,
   output logic [AXI_TAG_WIDTH-1:0]  m_d_tag,
   output logic                      m_d_valid,
   input  logic                      m_d_ready,
   // DMA read status
   input  logic [AXI_TAG_WIDTH-1:0]  rs_tag,
   input  logic [3:0]                rs_error,
   input  logic                      rs_valid,
   // status / debug
   input  logic                      clr_err,
   output logic [CNT_WIDTH-1:0]      w_outstanding,
   output logic [CNT_WIDTH-1:0]      x_outstanding,
   output logic                      busy,
   output logic                      err,
   output logic                      err_src
);

   localparam int SEQ_WIDTH = AXI_TAG_WIDTH - 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

   // Source encoding doubles as tag bit 0.
   typedef enum logic {
      SRC_W = 1'b0,
      SRC_X = 1'b1
   } src_e;

   src_e                 last_grant;
   logic [SEQ_WIDTH-1:0] w_seq;
   logic [SEQ_WIDTH-1:0] x_seq;

   logic                 slot_free;
   logic                 elig_w;
   logic                 elig_x;
   logic                 grant_w;
   logic                 grant_x;

   logic                 rs_is_w;
   logic                 rs_is_x;
   logic                 dec_w;
   logic                 dec_x;
   logic                 underflow;
   logic                 err_set;
   logic [CNT_WIDTH-1:0] w_cnt_next;
   logic [CNT_WIDTH-1:0] x_cnt_next;

   // Sequence bits of the status tag are debug-only: completions are counted, not matched.
   logic                 unused_rs_seq;
   assign unused_rs_seq = ^rs_tag[AXI_TAG_WIDTH-1:1];

   assign slot_free = !m_d_valid || m_d_ready;
   assign elig_w    = s_wd_valid && (w_outstanding < CNT_MAX);
   assign elig_x    = s_xd_valid && (x_outstanding < CNT_MAX);

   // Round-robin grant: a lone eligible source wins, a tie goes to the source that did not win last.
   always_comb begin
      grant_w = 1'b0;
      grant_x = 1'b0;
      if (rstn && slot_free) begin
         if (elig_w && elig_x) begin
            if (last_grant == SRC_X) begin
               grant_w = 1'b1;
            end else begin
               grant_x = 1'b1;
            end
         end else if (elig_w) begin
            grant_w = 1'b1;
         end else if (elig_x) begin
            grant_x = 1'b1;
         end
      end
   end

   assign s_wd_ready = grant_w;
   assign s_xd_ready = grant_x;

   // Credit accounting: issue increments, completion decrements, a completion on an empty counter is an underflow.
   always_comb begin
      rs_is_w    = rs_valid && (rs_tag[0] == SRC_W);
      rs_is_x    = rs_valid && (rs_tag[0] == SRC_X);
      dec_w      = rs_is_w && (w_outstanding != '0);
      dec_x      = rs_is_x && (x_outstanding != '0);
      underflow  = (rs_is_w && (w_outstanding == '0)) ||
                   (rs_is_x && (x_outstanding == '0));
      err_set    = rs_valid && ((rs_error != 4'd0) || underflow);
      w_cnt_next = w_outstanding + CNT_WIDTH'(grant_w) - CNT_WIDTH'(dec_w);
      x_cnt_next = x_outstanding + CNT_WIDTH'(grant_x) - CNT_WIDTH'(dec_x);
   end

   // Output slot: load the granted descriptor, hold while stalled, drop valid when free and nothing granted.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         m_d_valid <= 1'b0;
         m_d_addr  <= '0;
         m_d_len   <= '0;
         m_d_tag   <= '0;
      end else if (slot_free) begin
         m_d_valid <= grant_w || grant_x;
         if (grant_w) begin
            m_d_addr <= s_wd_addr;
            m_d_len  <= s_wd_len;
            m_d_tag  <= {w_seq, 1'b0};
         end else if (grant_x) begin
            m_d_addr <= s_xd_addr;
            m_d_len  <= s_xd_len;
            m_d_tag  <= {x_seq, 1'b1};
         end
      end
   end

   // Arbitration history and per-source sequence numbers (wrap naturally at the sequence width).
   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_grant <= SRC_X;
         w_seq      <= '0;
         x_seq      <= '0;
      end else begin
         if (grant_w) begin
            last_grant <= SRC_W;
            w_seq      <= w_seq + 1'b1;
         end
         if (grant_x) begin
            last_grant <= SRC_X;
            x_seq      <= x_seq + 1'b1;
         end
      end
   end

   // In-flight counters; the new values gate eligibility from the next cycle on.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_outstanding <= '0;
         x_outstanding <= '0;
      end else begin
         w_outstanding <= w_cnt_next;
         x_outstanding <= x_cnt_next;
      end
   end

   // Sticky error: the source of the first error is kept until cleared; a new error beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err     <= 1'b0;
         err_src <= 1'b0;
      end else begin
         if (err_set && !err) begin
            err_src <= rs_tag[0];
         end
         if (err_set) begin
            err <= 1'b1;
         end else if (clr_err) begin
            err <= 1'b0;
         end
      end
   end

   assign busy = m_d_valid || (w_outstanding != '0) || (x_outstanding != '0);

endmodule

// File: tb/tb_dma_rd_desc_arbiter.sv
// Bench for dma_rd_desc_arbiter: hand-derived vector table, directed corner sequences, randomized traffic.
// Every cycle is compared against a behavioural model of credits, round-robin and sticky error.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dma_rd_desc_arbiter;

   localparam int AW = 32;
   localparam int LW = 32;
   localparam int TW = 8;
   localparam int MO = 4;
   localparam int CW = $clog2(MO + 1);

   logic          clk;
   logic          rstn;
   logic [AW-1:0] s_wd_addr, s_xd_addr, m_d_addr;
   logic [LW-1:0] s_wd_len, s_xd_len, m_d_len;
   logic          s_wd_valid, s_wd_ready, s_xd_valid, s_xd_ready;
   logic [TW-1:0] m_d_tag, rs_tag;
   logic          m_d_valid, m_d_ready;
   logic [3:0]    rs_error;
   logic          rs_valid, clr_err;
   logic [CW-1:0] w_outstanding, x_outstanding;
   logic          busy, err, err_src;

   dma_rd_desc_arbiter #(
      .AXI_ADDR_WIDTH (AW),
      .AXI_LEN_WIDTH  (LW),
      .AXI_TAG_WIDTH  (TW),
      .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .s_wd_addr(s_wd_addr), .s_wd_len(s_wd_len), .s_wd_valid(s_wd_valid), .s_wd_ready(s_wd_ready),
      .s_xd_addr(s_xd_addr), .s_xd_len(s_xd_len), .s_xd_valid(s_xd_valid), .s_xd_ready(s_xd_ready),
      .m_d_addr(m_d_addr), .m_d_len(m_d_len), .m_d_tag(m_d_tag), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
      .rs_tag(rs_tag), .rs_error(rs_error), .rs_valid(rs_valid), .clr_err(clr_err),
      .w_outstanding(w_outstanding), .x_outstanding(x_outstanding),
      .busy(busy), .err(err), .err_src(err_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         rstn;
      bit         wv;
      bit         xv;
      bit         mrdy;
      bit         rsv;
      logic [7:0] rstag;
      logic [3:0] rserr;
      bit         clr;
   } stim_t;

   typedef struct {
      stim_t      s;
      bit         e_wrdy;
      bit         e_xrdy;
      bit         e_mvld;
      logic [7:0] e_tag;
      int         e_wout;
      int         e_xout;
      bit         e_busy;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   bit         mdl_ok = 0;
   bit         mdl_vld;
   logic [31:0] mdl_addr, mdl_len;
   logic [7:0] mdl_tag;
   int         mdl_wout, mdl_xout, mdl_wseq, mdl_xseq;
   int         mdl_last;   // 0 = W won last, 1 = X won last
   bit         mdl_err, mdl_err_src;
   logic [31:0] last_wa;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t mks(bit r, bit wv, bit xv, bit mrdy, bit rsv,
                                 logic [7:0] t, logic [3:0] e, bit clr);
      stim_t s;
      s.rstn = r; s.wv = wv; s.xv = xv; s.mrdy = mrdy;
      s.rsv = rsv; s.rstag = t; s.rserr = e; s.clr = clr;
      return s;
   endfunction

   // Which source the rules award this cycle: 0 none, 1 W, 2 X.
   function automatic int pick(stim_t s);
      bit free, ew, ex;
      free = !mdl_vld || s.mrdy;
      ew   = s.wv && (mdl_wout < MO);
      ex   = s.xv && (mdl_xout < MO);
      if (!s.rstn || !free) return 0;
      if (ew && ex) return (mdl_last == 1) ? 1 : 2;
      if (ew) return 1;
      if (ex) return 2;
      return 0;
   endfunction

   // One clock cycle: drive, compare against the model, then advance the model past the rising edge.
   task automatic cycle(input stim_t s);
      logic [31:0] wa, wl, xa, xl;
      int g, pw, px;
      bit uf, eset;
      @(negedge clk);
      wa = $urandom; wl = $urandom; xa = $urandom; xl = $urandom;
      last_wa    = wa;
      rstn       = s.rstn;
      s_wd_valid = s.wv;  s_wd_addr = wa; s_wd_len = wl;
      s_xd_valid = s.xv;  s_xd_addr = xa; s_xd_len = xl;
      m_d_ready  = s.mrdy;
      rs_valid   = s.rsv; rs_tag = s.rstag; rs_error = s.rserr;
      clr_err    = s.clr;
      #1;
      g = 0;
      if (mdl_ok) begin
         g = pick(s);
         chk("s_wd_ready", s_wd_ready, g == 1);
         chk("s_xd_ready", s_xd_ready, g == 2);
         chk("m_d_valid", m_d_valid, mdl_vld);
         if (mdl_vld) begin
            chk("m_d_addr", m_d_addr, mdl_addr);
            chk("m_d_len", m_d_len, mdl_len);
            chk("m_d_tag", m_d_tag, mdl_tag);
         end
         chk("w_outstanding", w_outstanding, mdl_wout);
         chk("x_outstanding", x_outstanding, mdl_xout);
         chk("busy", busy, mdl_vld || mdl_wout != 0 || mdl_xout != 0);
         chk("err", err, mdl_err);
         chk("err_src", err_src, mdl_err_src);
      end
      if (!s.rstn) begin
         mdl_ok = 1; mdl_vld = 0; mdl_addr = 0; mdl_len = 0; mdl_tag = 0;
         mdl_wout = 0; mdl_xout = 0; mdl_wseq = 0; mdl_xseq = 0; mdl_last = 1;
         mdl_err = 0; mdl_err_src = 0;
      end else if (mdl_ok) begin
         pw = mdl_wout; px = mdl_xout;
         if (!mdl_vld || s.mrdy) mdl_vld = (g != 0);
         if (g == 1) begin
            mdl_addr = wa; mdl_len = wl; mdl_tag = 8'(mdl_wseq * 2);
            mdl_wseq = (mdl_wseq + 1) % 128; mdl_last = 0; mdl_wout++;
         end else if (g == 2) begin
            mdl_addr = xa; mdl_len = xl; mdl_tag = 8'(mdl_xseq * 2 + 1);
            mdl_xseq = (mdl_xseq + 1) % 128; mdl_last = 1; mdl_xout++;
         end
         uf = 0;
         if (s.rsv) begin
            if (s.rstag[0] == 1'b0) begin
               if (pw == 0) uf = 1; else mdl_wout--;
            end else begin
               if (px == 0) uf = 1; else mdl_xout--;
            end
         end
         eset = s.rsv && (s.rserr != 0 || uf);
         if (eset && !mdl_err) mdl_err_src = s.rstag[0];
         if (eset) mdl_err = 1;
         else if (s.clr) mdl_err = 0;
      end
   endtask

   function automatic vec_t mkv(bit wv, bit xv, bit rsv, logic [7:0] rt,
                                bit ew, bit ex, bit ev, logic [7:0] et,
                                int ewo, int exo, bit eb);
      vec_t v;
      v.s = mks(1, wv, xv, 1, rsv, rt, 4'h0, 0);
      v.e_wrdy = ew; v.e_xrdy = ex; v.e_mvld = ev; v.e_tag = et;
      v.e_wout = ewo; v.e_xout = exo; v.e_busy = eb;
      return v;
   endfunction

   stim_t idle, rst, ww, bb;

   initial begin
      vec_t tbl[9];
      logic [31:0] held_addr;
      rstn = 0; s_wd_valid = 0; s_xd_valid = 0; m_d_ready = 0;
      rs_valid = 0; rs_tag = 0; rs_error = 0; clr_err = 0;
      s_wd_addr = 0; s_wd_len = 0; s_xd_addr = 0; s_xd_len = 0;

      idle = mks(1, 0, 0, 1, 0, 8'h00, 4'h0, 0);
      rst  = mks(0, 0, 0, 1, 0, 8'h00, 4'h0, 0);
      ww   = mks(1, 1, 0, 1, 0, 8'h00, 4'h0, 0);
      bb   = mks(1, 1, 1, 1, 0, 8'h00, 4'h0, 0);

      // Both sources streaming, status two cycles after each grant (values are observed in each row's cycle).
      //             wv xv rsv tag   | wrdy xrdy mvld tag  wout xout busy
      tbl[0] = mkv(1, 1, 0, 8'h00,   1, 0, 0, 8'h00, 0, 0, 0);
      tbl[1] = mkv(1, 1, 0, 8'h00,   0, 1, 1, 8'h00, 1, 0, 1);
      tbl[2] = mkv(1, 1, 1, 8'h00,   1, 0, 1, 8'h01, 1, 1, 1);
      tbl[3] = mkv(1, 1, 1, 8'h01,   0, 1, 1, 8'h02, 1, 1, 1);
      tbl[4] = mkv(1, 1, 1, 8'h02,   1, 0, 1, 8'h03, 1, 1, 1);
      tbl[5] = mkv(1, 1, 1, 8'h03,   0, 1, 1, 8'h04, 1, 1, 1);
      tbl[6] = mkv(0, 0, 1, 8'h04,   0, 0, 1, 8'h05, 1, 1, 1);
      tbl[7] = mkv(0, 0, 1, 8'h05,   0, 0, 0, 8'h00, 0, 1, 1);
      tbl[8] = mkv(0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0, 0, 0);

      cycle(rst);
      cycle(rst);
      chk("rst m_d_valid", m_d_valid, 0);
      chk("rst m_d_addr", m_d_addr, 0);
      chk("rst m_d_len", m_d_len, 0);
      chk("rst m_d_tag", m_d_tag, 0);
      chk("rst w_out", w_outstanding, 0);
      chk("rst x_out", x_outstanding, 0);
      chk("rst err", err, 0);
      chk("rst err_src", err_src, 0);

      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].s);
         chk($sformatf("tbl%0d wrdy", i), s_wd_ready, tbl[i].e_wrdy);
         chk($sformatf("tbl%0d xrdy", i), s_xd_ready, tbl[i].e_xrdy);
         chk($sformatf("tbl%0d mvld", i), m_d_valid, tbl[i].e_mvld);
         if (tbl[i].e_mvld) chk($sformatf("tbl%0d tag", i), m_d_tag, tbl[i].e_tag);
         chk($sformatf("tbl%0d wout", i), w_outstanding, tbl[i].e_wout);
         chk($sformatf("tbl%0d xout", i), x_outstanding, tbl[i].e_xout);
         chk($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
         chk($sformatf("tbl%0d err", i), err, 0);
      end

      // W alone until credits run out, then one completion releases a fifth descriptor.
      cycle(rst);
      cycle(ww);
      for (int i = 0; i < 4; i++) begin
         cycle(ww);
         chk("wonly tag", m_d_tag, 8'(i * 2));
      end
      chk("wonly limit wout", w_outstanding, 4);
      chk("wonly limit wrdy", s_wd_ready, 0);
      cycle(mks(1, 1, 0, 1, 1, 8'h00, 4'h0, 0));
      chk("wonly stall wrdy", s_wd_ready, 0);
      cycle(ww);
      chk("wonly 5th wrdy", s_wd_ready, 1);
      cycle(ww);
      chk("wonly 5th tag", m_d_tag, 8'h08);
      chk("wonly 5th mvld", m_d_valid, 1);

      // W pinned at its limit: X keeps winning even though it won last.
      for (int i = 0; i < 4; i++) begin
         cycle(bb);
         chk("credit x wins", s_xd_ready, 1);
         chk("credit w skipped", s_wd_ready, 0);
      end

      // Output stall with both sources pending.
      cycle(rst);
      cycle(bb);
      held_addr = last_wa;
      for (int i = 0; i < 5; i++) begin
         cycle(mks(1, 1, 1, 0, 0, 8'h00, 4'h0, 0));
         chk("stall mvld", m_d_valid, 1);
         chk("stall tag", m_d_tag, 8'h00);
         chk("stall addr", m_d_addr, held_addr);
         chk("stall wrdy", s_wd_ready, 0);
         chk("stall xrdy", s_xd_ready, 0);
      end
      cycle(bb);
      chk("unstall xrdy", s_xd_ready, 1);
      chk("unstall wrdy", s_wd_ready, 0);
      cycle(idle);
      chk("unstall tag", m_d_tag, 8'h01);

      // Sticky error: set, set beats clear, clear alone.
      cycle(mks(1, 0, 0, 1, 1, 8'h03, 4'h2, 0));
      cycle(mks(1, 0, 0, 1, 1, 8'h00, 4'h1, 1));
      chk("err set", err, 1);
      chk("err_src x", err_src, 1);
      chk("err x dec", x_outstanding, 0);
      cycle(mks(1, 0, 0, 1, 0, 8'h00, 4'h0, 1));
      chk("err set beats clr", err, 1);
      chk("err_src kept", err_src, 1);
      cycle(idle);
      chk("err cleared", err, 0);

      // Underflow on an empty W counter.
      cycle(mks(1, 0, 0, 1, 1, 8'h00, 4'h0, 0));
      cycle(idle);
      chk("uflow wout", w_outstanding, 0);
      chk("uflow err", err, 1);
      chk("uflow err_src", err_src, 0);

      // Reset in the middle of a burst, then stale status from before the reset.
      cycle(bb);
      cycle(bb);
      cycle(bb);
      cycle(mks(0, 1, 1, 1, 0, 8'h00, 4'h0, 0));
      cycle(mks(1, 0, 0, 1, 1, 8'h01, 4'h0, 0));
      chk("midrst mvld", m_d_valid, 0);
      chk("midrst tag", m_d_tag, 0);
      chk("midrst wout", w_outstanding, 0);
      chk("midrst xout", x_outstanding, 0);
      chk("midrst busy", busy, 0);
      chk("midrst err", err, 0);
      cycle(idle);
      chk("stale status err", err, 1);
      chk("stale status src", err_src, 1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         stim_t s;
         bit src;
         s.rstn  = ($urandom_range(0, 499) != 0);
         s.wv    = ($urandom_range(0, 3) != 0);
         s.xv    = ($urandom_range(0, 3) != 0);
         s.mrdy  = ($urandom_range(0, 3) != 0);
         src     = $urandom_range(0, 1);
         s.rsv   = ($urandom_range(0, 9) < 4);
         if (s.rsv && ((src ? mdl_xout : mdl_wout) == 0)) s.rsv = ($urandom_range(0, 9) == 0);
         s.rstag = {7'($urandom), src};
         s.rserr = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         s.clr   = ($urandom_range(0, 19) == 0);
         cycle(s);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dma_rd_desc_arbiter.md
Name: dma_rd_desc_arbiter

Overview:
Shares one MM2S DMA read-descriptor channel between the weights descriptor stream (W) and the pixels descriptor stream (X) produced by the DMA controller. It uses round-robin arbitration and per-source credit limits on in-flight transfers. It tags each descriptor with source and sequence number, and routes DMA read-status completions back to per-source outstanding counters. It sits between the DMA controller's m_wd_*/m_xd_* outputs and a single DMA read-descriptor port.

Parameters:
AXI_ADDR_WIDTH, 32, descriptor address width
AXI_LEN_WIDTH, 32, descriptor byte-length width
AXI_TAG_WIDTH, 8, descriptor/status tag width; bit 0 is source, bits [AXI_TAG_WIDTH-1:1] are sequence
MAX_OUTSTANDING, 4, max issued-but-not-completed transfers per source (1..2^(AXI_TAG_WIDTH-1))

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
s_wd_addr  in  AXI_ADDR_WIDTH  weights descriptor address
s_wd_len  in  AXI_LEN_WIDTH  weights descriptor length
s_wd_valid  in  1  weights descriptor valid
s_wd_ready  out  1  weights descriptor accepted this cycle
s_xd_addr  in  AXI_ADDR_WIDTH  pixels descriptor address
s_xd_len  in  AXI_LEN_WIDTH  pixels descriptor length
s_xd_valid  in  1  pixels descriptor valid
s_xd_ready  out  1  pixels descriptor accepted this cycle
m_d_addr  out  AXI_ADDR_WIDTH  merged descriptor address
m_d_len  out  AXI_LEN_WIDTH  merged descriptor length
m_d_tag  out  AXI_TAG_WIDTH  {seq, src}
m_d_valid  out  1  merged descriptor valid
m_d_ready  in  1  DMA accepts descriptor
rs_tag  in  AXI_TAG_WIDTH  read-status tag
rs_error  in  4  read-status error code (0 = OK)
rs_valid  in  1  read-status valid (single-cycle pulse)
clr_err  in  1  clears sticky error
w_outstanding  out  $clog2(MAX_OUTSTANDING+1)  W in-flight count
x_outstanding  out  $clog2(MAX_OUTSTANDING+1)  X in-flight count
busy  out  1  m_d_valid or any outstanding non-zero
err  out  1  sticky error flag
err_src  out  1  source (tag bit 0) of the first error since clear

Behaviour:
- Reset: m_d_valid=0, m_d_addr/len/tag=0, both outstanding=0, both seq=0, err=0, err_src=0, last_grant=X, so W wins the first tie.
- Output register stage: slot is free when !m_d_valid || m_d_ready. This gives full throughput, one descriptor per cycle.
- Eligibility: elig_w = s_wd_valid && w_outstanding < MAX_OUTSTANDING; elig_x likewise.
- Grant, only when the slot is free:
  - Only one source eligible: grant it.
  - Both eligible: grant the source != last_grant.
  - s_*_ready = grant for that source. Ready is combinational and may depend on the other source's valid.
- On grant:
  - Next cycle m_d_valid=1 with the source's addr/len and tag={seq_src, src}, where src W=0, X=1.
  - seq_src increments, wrapping modulo 2^(AXI_TAG_WIDTH-1).
  - last_grant updates to the granted source.
  - The source's outstanding count increments.
- No grant while the slot is free: m_d_valid falls to 0.
- m_d_* are held stable while m_d_valid && !m_d_ready.
- Completion: on rs_valid, the counter selected by rs_tag[0] decrements.
  - Increment and decrement in the same cycle on the same counter leave it unchanged.
  - rs_valid while the selected counter is 0 is an underflow: the counter stays 0 and err is set.
- Error:
  - err sets on rs_valid && (rs_error != 0 || underflow).
  - err_src is latched only when err is 0 that cycle.
  - clr_err clears err; a set in the same cycle wins over the clear.
- Credit exhaustion: a source at MAX_OUTSTANDING is skipped, so the other source proceeds even if it granted last.
- Credits free in the cycle after rs_valid, because the counters are registered.
- Sequence numbers are for debug and ordering checks only; completions are counted, not matched.
- Reset mid-operation returns everything to reset values on the next edge. In-flight DMA status after reset is treated as an underflow and flagged.

Test Plan:
- Both valid continuously, m_d_ready=1, MAX_OUTSTANDING=4, rs_valid for each tag 2 cycles after issue -> tags 0x00,0x01,0x02,0x03,0x04,0x05 (W,X alternating, seq 0,0,1,1,2,2); one descriptor per cycle.
- Only W valid, no status -> 4 descriptors issue with tags 0x00,0x02,0x04,0x06, then s_wd_ready=0 and w_outstanding=4. One rs_valid with tag 0x00 -> a 5th issues the following cycle.
- W at credit limit and X valid -> X granted every free cycle despite last_grant=X.
- m_d_ready=0 for 5 cycles with both sources valid -> m_d_* stable, both s_*_ready=0. On ready, the next grant goes to the alternate source.
- rs_valid with rs_error=4'h2 and tag 0x03 -> err=1, err_src=1, x count decrements. clr_err in the same cycle as a second error -> err stays 1. clr_err alone -> err=0.
- rs_valid with tag 0x00 while w_outstanding=0 -> w_outstanding stays 0, err=1, err_src=0. Reset asserted mid-burst -> all outputs 0 on the next cycle.
